// File: rtl/mem_pkg.sv
// Shared constants and request/response bundles for the dual-port memory.
package mem_pkg;
   localparam int MEM_DATA_WIDTH = 32;
   localparam int MEM_NUM_BYTES  = MEM_DATA_WIDTH / 8;
   localparam int MEM_OFF        = $clog2(MEM_NUM_BYTES);

   typedef struct packed {
      logic                      req;
      logic [31:0]               addr;
      logic                      we;
      logic [MEM_NUM_BYTES-1:0]  be;
      logic [MEM_DATA_WIDTH-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic                      rvalid;
      logic                      err;
      logic [MEM_DATA_WIDTH-1:0] rdata;
   } mem_rsp_t;
endpackage

// File: rtl/dp_ram.sv
// True dual-port byte-writable RAM, read-first, synchronous reads.
// On a same-word write collision port A's enabled bytes take priority.
module dp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    re_a,
   input  logic                    we_a,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH/8-1:0] be_a,
   input  logic [DATA_WIDTH-1:0]   wdata_a,
   output logic [DATA_WIDTH-1:0]   rdata_a,
   input  logic                    re_b,
   input  logic                    we_b,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH/8-1:0] be_b,
   input  logic [DATA_WIDTH-1:0]   wdata_b,
   output logic [DATA_WIDTH-1:0]   rdata_b
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Reads sample old contents; B bytes are written first so A overrides them.
   always_ff @(posedge clk) begin
      if (re_a) rdata_a <= mem[addr_a];
      if (re_b) rdata_b <= mem[addr_b];
      for (int i = 0; i < NB; i++) begin
         if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
         if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      end
   end
endmodule

// File: rtl/dp_memory_wrapper.sv
// Dual-port memory wrapper: address decode, range check, grant and
// registered response for a core bus (A) and an auxiliary port (B).
// Storage lives at <inst>.mem.MX.mem so simulations can preload it.
module dp_memory_wrapper
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
   parameter int M_ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_req_a,
   input  logic [31:0]             data_addr_a,
   input  logic                    data_we_a,
   input  logic [DATA_WIDTH/8-1:0] data_be_a,
   input  logic [DATA_WIDTH-1:0]   data_wdata_a,
   output logic                    data_rvalid_a,
   output logic                    data_err_a,
   output logic [DATA_WIDTH-1:0]   data_rdata_a,
   output logic                    data_gnt_a,
   input  logic                    data_req_b,
   input  logic [31:0]             data_addr_b,
   input  logic                    data_we_b,
   input  logic [DATA_WIDTH/8-1:0] data_be_b,
   input  logic [DATA_WIDTH-1:0]   data_wdata_b,
   output logic                    data_rvalid_b,
   output logic                    data_err_b,
   output logic [DATA_WIDTH-1:0]   data_rdata_b,
   output logic                    data_gnt_b
);
   localparam int NB  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(NB);

   mem_req_t p_req [2];
   mem_rsp_t p_rsp [2];

   logic [1:0]                   rd_en, wr_en;
   logic [1:0][M_ADDR_WIDTH-1:0] idx;
   logic [1:0][DATA_WIDTH-1:0]   ram_q;

   assign p_req[0] = '{req: data_req_a, addr: data_addr_a, we: data_we_a,
                       be: data_be_a, wdata: data_wdata_a};
   assign p_req[1] = '{req: data_req_b, addr: data_addr_b, we: data_we_b,
                       be: data_be_b, wdata: data_wdata_b};

   // No back-pressure: every request is accepted in its own cycle.
   assign data_gnt_a = data_req_a;
   assign data_gnt_b = data_req_b;

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic oor;
      logic rvalid_q, err_q, from_ram_q;

      assign idx[p]   = p_req[p].addr[OFF+M_ADDR_WIDTH-1:OFF];
      assign oor      = |p_req[p].addr[31:OFF+M_ADDR_WIDTH];
      // Writes are blocked while reset is held; memory itself is never cleared.
      assign wr_en[p] = p_req[p].req & p_req[p].we & ~oor & rst;
      assign rd_en[p] = p_req[p].req & ~p_req[p].we & ~oor;

      // Response flags; from_ram_q selects RAM data vs. zero and holds when idle.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            from_ram_q <= 1'b0;
         end else begin
            rvalid_q <= p_req[p].req;
            err_q    <= p_req[p].req & oor;
            if (p_req[p].req) from_ram_q <= rd_en[p];
         end
      end

      assign p_rsp[p] = '{rvalid: rvalid_q, err: err_q,
                          rdata: from_ram_q ? ram_q[p] : '0};
   end

   assign data_rvalid_a = p_rsp[0].rvalid;
   assign data_err_a    = p_rsp[0].err;
   assign data_rdata_a  = p_rsp[0].rdata;
   assign data_rvalid_b = p_rsp[1].rvalid;
   assign data_err_b    = p_rsp[1].err;
   assign data_rdata_b  = p_rsp[1].rdata;

   if (1) begin : mem
      dp_ram #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (M_ADDR_WIDTH)
      ) MX (
         .clk     (clk),
         .re_a    (rd_en[0]),
         .we_a    (wr_en[0]),
         .addr_a  (idx[0]),
         .be_a    (p_req[0].be),
         .wdata_a (p_req[0].wdata),
         .rdata_a (ram_q[0]),
         .re_b    (rd_en[1]),
         .we_b    (wr_en[1]),
         .addr_b  (idx[1]),
         .be_b    (p_req[1].be),
         .wdata_b (p_req[1].wdata),
         .rdata_b (ram_q[1])
      );
   end
endmodule

// File: tb/tb_dp_memory_wrapper.sv
// Bench for dp_memory_wrapper: word-level reference model plus directed vectors.
module tb_dp_memory_wrapper;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_a = 0, we_a = 0, req_b = 0, we_b = 0;
   logic [31:0] addr_a = 0, wdata_a = 0, addr_b = 0, wdata_b = 0;
   logic [3:0]  be_a = 0, be_b = 0;
   logic        rvalid_a, err_a, gnt_a, rvalid_b, err_b, gnt_b;
   logic [31:0] rdata_a, rdata_b;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   dp_memory_wrapper dut (
      .clk(clk), .rst(rst),
      .data_req_a(req_a), .data_addr_a(addr_a), .data_we_a(we_a),
      .data_be_a(be_a), .data_wdata_a(wdata_a),
      .data_rvalid_a(rvalid_a), .data_err_a(err_a),
      .data_rdata_a(rdata_a), .data_gnt_a(gnt_a),
      .data_req_b(req_b), .data_addr_b(addr_b), .data_we_b(we_b),
      .data_be_b(be_b), .data_wdata_b(wdata_b),
      .data_rvalid_b(rvalid_b), .data_err_b(err_b),
      .data_rdata_b(rdata_b), .data_gnt_b(gnt_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] model [int];
   logic        e_v_a = 0, e_e_a = 0, e_v_b = 0, e_e_b = 0;
   logic [31:0] e_d_a = 0, e_d_b = 0;
   bit          e_k_a = 1, e_k_b = 1;

   function automatic bit oor(input logic [31:0] a);
      return a >= 32'h0004_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
      return old;
   endfunction

   task automatic resp(input logic rq, input logic we, input logic [31:0] ad,
                       inout logic v, inout logic e, inout logic [31:0] d, inout bit k);
      v = rq;
      e = rq && oor(ad);
      if (rq) begin
         if (!we && !oor(ad)) begin
            k = model.exists(int'(ad / 4));
            d = k ? model[int'(ad / 4)] : 32'h0;
         end else begin
            d = 32'h0;
            k = 1;
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_v_a = 0; e_e_a = 0; e_d_a = 0; e_k_a = 1;
         e_v_b = 0; e_e_b = 0; e_d_b = 0; e_k_b = 1;
      end else begin
         resp(req_a, we_a, addr_a, e_v_a, e_e_a, e_d_a, e_k_a);
         resp(req_b, we_b, addr_b, e_v_b, e_e_b, e_d_b, e_k_b);
         if (req_b && we_b && !oor(addr_b))
            model[int'(addr_b / 4)] = merge(model.exists(int'(addr_b / 4)) ?
                                            model[int'(addr_b / 4)] : 32'h0, wdata_b, be_b);
         if (req_a && we_a && !oor(addr_a))
            model[int'(addr_a / 4)] = merge(model.exists(int'(addr_a / 4)) ?
                                            model[int'(addr_a / 4)] : 32'h0, wdata_a, be_a);
      end
   end

   // Per-cycle compare of DUT outputs against the model.
   always @(posedge clk) begin
      chk("gnt_a", {31'b0, gnt_a}, {31'b0, req_a});
      chk("gnt_b", {31'b0, gnt_b}, {31'b0, req_b});
      #1;
      chk("mdl_rvalid_a", {31'b0, rvalid_a}, {31'b0, e_v_a});
      chk("mdl_err_a",    {31'b0, err_a},    {31'b0, e_e_a});
      chk("mdl_rvalid_b", {31'b0, rvalid_b}, {31'b0, e_v_b});
      chk("mdl_err_b",    {31'b0, err_b},    {31'b0, e_e_b});
      if (e_k_a) chk("mdl_rdata_a", rdata_a, e_d_a);
      if (e_k_b) chk("mdl_rdata_b", rdata_b, e_d_b);
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input logic ra, input logic wa, input logic [31:0] aa,
                         input logic [3:0] ba, input logic [31:0] da,
                         input logic rb, input logic wb, input logic [31:0] ab,
                         input logic [3:0] bb, input logic [31:0] db);
      req_a = ra; we_a = wa; addr_a = aa; be_a = ba; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; be_b = bb; wdata_b = db;
   endtask

   task automatic drive(input logic ra, input logic wa, input logic [31:0] aa,
                        input logic [3:0] ba, input logic [31:0] da,
                        input logic rb, input logic wb, input logic [31:0] ab,
                        input logic [3:0] bb, input logic [31:0] db);
      @(negedge clk);
      set_in(ra, wa, aa, ba, da, rb, wb, ab, bb, db);
      @(posedge clk);
      #1;
   endtask

   task automatic rd_a(input logic [31:0] a);
      drive(1, 0, a, 4'hF, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1 rst = 1'b0;
      dut.mem.MX.mem[0]  = 32'hDEADBEEF; model[0]  = 32'hDEADBEEF;
      dut.mem.MX.mem[8]  = 32'h0;        model[8]  = 32'h0;
      dut.mem.MX.mem[16] = 32'h0;        model[16] = 32'h0;
      dut.mem.MX.mem[64] = 32'hAAAAAAAA; model[64] = 32'hAAAAAAAA;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'h0);
      chk("rst_err_a",    {31'b0, err_a},    32'h0);
      chk("rst_rdata_a",  rdata_a,           32'h0);
      chk("rst_rdata_b",  rdata_b,           32'h0);
      @(negedge clk) rst = 1'b1;

      // Preloaded read
      @(negedge clk);
      set_in(1, 0, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0);
      #1 chk("gnt_a_req_cycle", {31'b0, gnt_a}, 32'h1);
      @(posedge clk); #1;
      chk("rd0_rvalid", {31'b0, rvalid_a}, 32'h1);
      chk("rd0_err",    {31'b0, err_a},    32'h0);
      chk("rd0_rdata",  rdata_a,           32'hDEADBEEF);

      // Byte-enabled write then read back
      drive(1, 1, 32'h100, 4'b0101, 32'h11223344, 0, 0, 0, 0, 0);
      chk("wr_rvalid", {31'b0, rvalid_a}, 32'h1);
      chk("wr_err",    {31'b0, err_a},    32'h0);
      chk("wr_rdata",  rdata_a,           32'h0);
      rd_a(32'h100);
      chk("be_merge", rdata_a, 32'hAA22AA44);
      idle();
      chk("hold_rvalid", {31'b0, rvalid_a}, 32'h0);
      chk("hold_rdata",  rdata_a,           32'hAA22AA44);

      // Out of range: read, write, then confirm word 0 untouched
      rd_a(32'h0004_0000);
      chk("oor_rd_err",   {31'b0, err_a}, 32'h1);
      chk("oor_rd_rdata", rdata_a,        32'h0);
      drive(1, 1, 32'h0004_0000, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      chk("oor_wr_err", {31'b0, err_a}, 32'h1);
      rd_a(32'h0);
      chk("oor_wr_nomod", rdata_a, 32'hDEADBEEF);
      drive(1, 0, 32'hFFFF_FFFC, 4'hF, 0, 0, 0, 0, 0, 0);
      chk("oor_top_err", {31'b0, err_a}, 32'h1);

      // Cross-port read-first, then read the new value
      drive(1, 1, 32'h20, 4'hF, 32'h55555555, 1, 0, 32'h20, 4'hF, 0);
      chk("rdfirst_b", rdata_b, 32'h0);
      drive(0, 0, 0, 0, 0, 1, 0, 32'h20, 4'hF, 0);
      chk("after_wr_b", rdata_b, 32'h55555555);

      // Same-word dual writes: A wins, then byte merge
      drive(1, 1, 32'h40, 4'hF, 32'h1, 1, 1, 32'h40, 4'hF, 32'h2);
      rd_a(32'h40);
      chk("dual_wr_a_wins", rdata_a, 32'h1);
      drive(1, 1, 32'h40, 4'b0001, 32'h000000AA, 1, 1, 32'h40, 4'b1110, 32'h11223344);
      drive(0, 0, 0, 0, 0, 1, 0, 32'h40, 4'hF, 0);
      chk("dual_wr_merge", rdata_b, 32'h112233AA);

      // Back-to-back reads on both ports
      drive(1, 0, 32'h100, 4'hF, 0, 1, 0, 32'h0, 4'hF, 0);
      drive(1, 0, 32'h0, 4'hF, 0, 1, 0, 32'h100, 4'hF, 0);
      chk("b2b_a", rdata_a, 32'hDEADBEEF);
      chk("b2b_b", rdata_b, 32'hAA22AA44);

      // Reset mid-stream with a request pending
      @(negedge clk);
      set_in(1, 1, 32'h100, 4'hF, 32'h0BADF00D, 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_rvalid_a", {31'b0, rvalid_a}, 32'h0);
      chk("async_err_a",    {31'b0, err_a},    32'h0);
      chk("async_rdata_a",  rdata_a,           32'h0);
      chk("async_rdata_b",  rdata_b,           32'h0);
      @(posedge clk); #1;
      chk("in_rst_gnt_a",   {31'b0, gnt_a},    32'h1);
      chk("in_rst_rvalid",  {31'b0, rvalid_a}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("post_rst_rvalid", {31'b0, rvalid_a}, 32'h0);
      rd_a(32'h100);
      chk("mem_kept", rdata_a, 32'hAA22AA44);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/dp_memory_wrapper.md
Name: dp_memory_wrapper

Overview:
- Dual-port, word-organised, byte-writable on-chip memory serving a core's combined instruction/data bus on port A; port B is an auxiliary port.
- Both ports share one storage array, sized 2^M_ADDR_WIDTH words of DATA_WIDTH bits.
- Requests are always granted in the cycle they are presented. Read data returns with fixed 1-cycle latency.
- Storage is preloadable by simulation hex load through the hierarchical path <inst>.mem.MX.mem.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- M_ADDR_WIDTH, 16: log2 of the word count. The default gives 65536 words = 256 KiB.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_req_a  in  1  port A request.
- data_addr_a  in  32  port A byte address.
- data_we_a  in  1  port A write enable (1 = write, 0 = read).
- data_be_a  in  DATA_WIDTH/8  port A byte enables.
- data_wdata_a  in  DATA_WIDTH  port A write data.
- data_rvalid_a  out  1  port A response valid.
- data_err_a  out  1  port A error flag, qualified by rvalid.
- data_rdata_a  out  DATA_WIDTH  port A read data, qualified by rvalid.
- data_gnt_a  out  1  port A grant.
- data_req_b, data_addr_b, data_we_b, data_be_b, data_wdata_b, data_rvalid_b, data_err_b, data_rdata_b, data_gnt_b: same as port A, for port B.

Behaviour:
- Address decode:
  - OFF = log2(DATA_WIDTH/8).
  - Word index = addr[OFF+M_ADDR_WIDTH-1 : OFF]; low OFF bits are ignored.
  - Out of range when addr[31 : OFF+M_ADDR_WIDTH] != 0.
- Grant: data_gnt_x = data_req_x, combinational. There are no stalls and no back-pressure.
- Write (req & we & in range), at the clock edge: for each i with be[i]=1, word[idx][8i+7:8i] <= wdata[8i+7:8i]. Bytes with be[i]=0 are unchanged. Byte lanes are little-endian.
- Out-of-range write: memory is not modified.
- Response, registered, exactly one cycle after the request cycle, for reads and writes alike:
  - rvalid <= req.
  - err <= req & out-of-range.
  - rdata <= word[idx] for an in-range read; 0 for out-of-range or a write.
  - rdata holds its last value when req=0.
- Read-during-write, same port or across ports to the same word in the same cycle: read returns the old contents (read-first).
- Simultaneous writes from A and B to the same word: port A's enabled bytes win. Bytes enabled only by B take B's data.
- Reset (rst=0), asynchronous:
  - rvalid_a/b = 0, err_a/b = 0, rdata_a/b = 0 immediately.
  - Memory contents are NOT cleared, so preloaded programs survive reset.
  - A request in flight when reset asserts is dropped; no response is produced.
  - While in reset, writes are ignored and gnt still follows req.
- Uninitialised words read as X in simulation; no implicit zeroing.
- Ports are fully independent. Back-to-back requests every cycle yield back-to-back responses.

Decomposition:
- Package mem_pkg holds:
  - localparam for byte-lane count (DATA_WIDTH/8);
  - OFF;
  - a req/rsp struct typedef pair (req, addr, we, be, wdata / rvalid, err, rdata).
- One sub-module dp_ram, instantiated with the instance name MX:
  - contains the storage array, named mem;
  - true dual-port, byte-write, read-first, with synchronous reads on both ports.
- The wrapper adds address decode, range check, grant, and the response/err registers.

Test Plan:
- Preload via $readmemh, word 0 = 0xDEADBEEF; A reads addr 0x0 -> next cycle rvalid_a=1, err_a=0, rdata_a=0xDEADBEEF; gnt_a=1 in the request cycle.
- A writes addr 0x100, be=0b0101, wdata=0x11223344 over 0xAAAAAAAA; then read -> 0xAA22AA44. Write response has rvalid=1, err=0.
- A reads addr 0x00040000 (beyond 256 KiB) -> rvalid=1, err=1, rdata=0. A write there leaves word 0 unchanged.
- Same cycle: A writes 0x55555555 to 0x20 while B reads 0x20 (old 0x0) -> B gets 0x0; a following B read gets 0x55555555.
- A and B both write 0x40 full-word (A=0x1, B=0x2) -> read 0x1. With A be=0b0001, B be=0b1110 -> bytes merge.
- Assert rst low mid-stream with req_a=1 -> rvalid_a/err_a/rdata_a go 0 asynchronously. Memory keeps its contents after reset is released (re-read 0x100 -> 0xAA22AA44).
